keypad_digit_entry: RTL and testbench
=====================================

Name: keypad_digit_entry

Overview:
- Upstream front end for the watch time-set path.
- Takes 10 raw push-button lines (keys 0–9) on the 1 kHz system clock, then synchronizes, debounces and one-hot-validates them.
- Runs a six-digit entry sequence (HH MM SS) and range-checks each digit against its time position.
- Hands accepted BCD digits one at a time to the watch core through a valid strobe plus position index.

Parameters:
- DEBOUNCE, 20: cycles a key vector must be stable before it is accepted (20 ms at 1 kHz).
- TIMEOUT, 10000: cycles without an accepted digit before an entry is aborted (10 s).

Ports:
- clk  in  1  system clock, 1 kHz.
- rst  in  1  asynchronous active-low reset.
- start  in  1  level; high for ≥1 cycle requests a new time entry.
- key_in  in  10  raw buttons, active-high, bit k = digit k.
- digit  out  4  BCD value of the accepted key.
- digit_pos  out  3  position of digit: 0=h_ten, 1=h_one, 2=m_ten, 3=m_one, 4=s_ten, 5=s_one.
- digit_valid  out  1  one-cycle strobe; digit and digit_pos are valid.
- entry_active  out  1  high while collecting digits.
- entry_done  out  1  one-cycle strobe, asserted in the same cycle as the position-5 digit_valid.
- entry_abort  out  1  one-cycle strobe on timeout.
- key_reject  out  1  one-cycle strobe on an illegal or out-of-range key press.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, pos=0, sync/stable vectors 0, counters 0.
- Synchronizer: 2 flops per key_in bit.
- Debounce:
  - A single counter clears whenever the synchronized vector differs from the previous cycle.
  - When the counter reaches DEBOUNCE-1, the synchronized vector is copied into the stable vector.
- Press event, generated only on a transition of the stable vector from all-zero to non-zero:
  - Exactly one bit set: press of that key.
  - More than one bit set: key_reject pulse, no digit.
  - A new press requires the stable vector to return to all-zero first. Holding a key or adding a second key produces no event.
- Latency: for a clean single-key press in COLLECT, digit_valid asserts exactly DEBOUNCE+3 cycles after key_in rises.
- FSM states:
  - IDLE: entry_active=0. Presses are ignored, with no key_reject. start=1 → COLLECT with pos=0 and the timeout counter cleared.
  - COLLECT: entry_active=1. Outcomes:
    - Press with digit within the limit for pos: digit_valid=1, digit=key, digit_pos=pos. If pos<5, pos increments. If pos==5, entry_done=1 in the same cycle and the FSM goes to IDLE with pos=0.
    - Press out of range: key_reject=1, pos unchanged, timeout not cleared.
    - Timeout counter reaches TIMEOUT-1: entry_abort=1 → IDLE, pos=0.
    - start=1: restart at pos=0, timeout cleared, no abort pulse. If start and a press coincide, start wins and the press is dropped.
  - The timeout counter clears on every accepted digit.
- Range limits:
  - pos0 ≤2.
  - pos1 ≤9 if the stored h_ten<2, else ≤3.
  - pos2 ≤5.
  - pos3 ≤9.
  - pos4 ≤5.
  - pos5 ≤9.
- An internal h_ten register holds the accepted pos0 digit.
- Reset mid-entry: returns to IDLE immediately, with no done/abort pulse after release.
- digit/digit_pos hold their last value when digit_valid=0.

Decomposition:
- Package watch_pkg holds:
  - position constants POS_H_TEN..POS_S_ONE;
  - per-position max-digit constants (2, 9, 5, 9, 5, 9; h_one max 3 when h_ten=2);
  - FSM state enum {IDLE, COLLECT}.
- Sub-module key_debounce, parameterized by width and DEBOUNCE: 2-flop synchronizer plus shared stable-vector debounce, outputting the stable vector.
- The top level holds the edge/one-hot detect, the FSM and the range check.

Test Plan:
- start pulse, then clean presses 1,2,3,4,5,6 each held 30 cycles with 30-cycle gaps → six digit_valid with digit_pos 0..5 and values 1..6. entry_done coincides with the 6th strobe, then entry_active=0.
- key 2 held 10 cycles with 1-cycle glitch pulses → no event. Same key held 30 cycles → exactly one digit_valid at DEBOUNCE+3 cycles after the final rise.
- In COLLECT at pos0 press 3 → key_reject, pos stays 0. Press 2 → accepted. At pos1 press 4 → key_reject. Press 3 → accepted at digit_pos=1.
- Keys 1 and 7 pressed together → key_reject, no digit_valid. Release both, press 7 alone at pos1 (h_ten=1) → accepted.
- start, one digit, then no presses for 10000 cycles → entry_abort pulse exactly TIMEOUT cycles after the last accepted digit, then entry_active=0. Presses in IDLE give no output.
- rst asserted mid-entry at pos3 → outputs 0 asynchronously. After release, a press without start gives no digit_valid.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-set path: digit positions,
// per-position digit limits and the digit-entry FSM states.
package watch_pkg;

   localparam logic [2:0] POS_H_TEN = 3'd0;
   localparam logic [2:0] POS_H_ONE = 3'd1;
   localparam logic [2:0] POS_M_TEN = 3'd2;
   localparam logic [2:0] POS_M_ONE = 3'd3;
   localparam logic [2:0] POS_S_TEN = 3'd4;
   localparam logic [2:0] POS_S_ONE = 3'd5;

   localparam logic [3:0] MAX_H_TEN    = 4'd2;
   localparam logic [3:0] MAX_H_ONE    = 4'd9;
   localparam logic [3:0] MAX_H_ONE_20 = 4'd3;
   localparam logic [3:0] MAX_M_TEN    = 4'd5;
   localparam logic [3:0] MAX_M_ONE    = 4'd9;
   localparam logic [3:0] MAX_S_TEN    = 4'd5;
   localparam logic [3:0] MAX_S_ONE    = 4'd9;

   typedef enum logic {
      IDLE,
      COLLECT
   } entry_state_t;

   // Largest legal digit at a position; hours 20-23 cap the hour units at 3.
   function automatic logic [3:0] max_digit(input logic [2:0] pos, input logic [3:0] h_ten);
      logic [3:0] lim;
      case (pos)
         POS_H_TEN: lim = MAX_H_TEN;
         POS_H_ONE: lim = (h_ten == MAX_H_TEN) ? MAX_H_ONE_20 : MAX_H_ONE;
         POS_M_TEN: lim = MAX_M_TEN;
         POS_M_ONE: lim = MAX_M_ONE;
         POS_S_TEN: lim = MAX_S_TEN;
         POS_S_ONE: lim = MAX_S_ONE;
         default:   lim = 4'd0;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer per key line followed by a single shared debounce
// counter that publishes the whole key vector once it has been quiet.
module key_debounce #(
   parameter int WIDTH    = 10,
   parameter int DEBOUNCE = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] key_in,
   output logic [WIDTH-1:0] stable
);

   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] stable_reg;
   logic [CW-1:0]    cnt_reg;
   logic             quiet;

   // sync1 is next cycle's synchronized value, so comparing it with sync2
   // detects a change of the synchronized vector one cycle early.
   assign quiet = (sync1_reg == sync2_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= key_in;
         sync2_reg <= sync1_reg;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg    <= '0;
         stable_reg <= '0;
      end else begin
         if (!quiet) begin
            cnt_reg <= '0;
         end else if (cnt_reg != CNT_LAST) begin
            cnt_reg <= cnt_reg + CW'(1);
         end
         if (quiet && cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
         end
      end
   end

   assign stable = stable_reg;

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad front end for setting the watch: debounced key presses become
// range-checked BCD digits for the six HH MM SS positions.
module keypad_digit_entry
   import watch_pkg::*;
#(
   parameter int DEBOUNCE = 20,
   parameter int TIMEOUT  = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] key_in,
   output logic [3:0] digit,
   output logic [2:0] digit_pos,
   output logic       digit_valid,
   output logic       entry_active,
   output logic       entry_done,
   output logic       entry_abort,
   output logic       key_reject
);

   localparam int NKEYS = 10;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   logic [NKEYS-1:0] stable;
   logic [NKEYS-1:0] stable_prev_reg;
   logic             press;
   logic             single_key;
   logic [3:0]       key_val;
   logic             in_range;

   entry_state_t     state_reg;
   logic [2:0]       pos_reg;
   logic [3:0]       h_ten_reg;
   logic [TW-1:0]    tcnt_reg;
   logic [3:0]       digit_reg;
   logic [2:0]       digit_pos_reg;
   logic             digit_valid_reg;
   logic             entry_active_reg;
   logic             entry_done_reg;
   logic             entry_abort_reg;
   logic             key_reject_reg;

   key_debounce #(
      .WIDTH    (NKEYS),
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .key_in (key_in),
      .stable (stable)
   );

   // Only the all-released to pressed transition counts; chords formed while
   // a key is held never reach the FSM.
   assign press      = (stable_prev_reg == '0) && (stable != '0);
   assign single_key = $onehot(stable);
   assign in_range   = (key_val <= max_digit(pos_reg, h_ten_reg));

   always_comb begin
      key_val = 4'd0;
      for (int i = 0; i < NKEYS; i++) begin
         if (stable[i]) begin
            key_val = 4'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= IDLE;
         pos_reg          <= POS_H_TEN;
         h_ten_reg        <= 4'd0;
         tcnt_reg         <= '0;
         stable_prev_reg  <= '0;
         digit_reg        <= 4'd0;
         digit_pos_reg    <= 3'd0;
         digit_valid_reg  <= 1'b0;
         entry_active_reg <= 1'b0;
         entry_done_reg   <= 1'b0;
         entry_abort_reg  <= 1'b0;
         key_reject_reg   <= 1'b0;
      end else begin
         stable_prev_reg <= stable;
         digit_valid_reg <= 1'b0;
         entry_done_reg  <= 1'b0;
         entry_abort_reg <= 1'b0;
         key_reject_reg  <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg        <= COLLECT;
                  entry_active_reg <= 1'b1;
                  pos_reg          <= POS_H_TEN;
                  tcnt_reg         <= '0;
               end
            end

            COLLECT: begin
               if (start) begin
                  pos_reg  <= POS_H_TEN;
                  tcnt_reg <= '0;
               end else if (tcnt_reg == TIMEOUT_LAST) begin
                  entry_abort_reg  <= 1'b1;
                  state_reg        <= IDLE;
                  entry_active_reg <= 1'b0;
                  pos_reg          <= POS_H_TEN;
                  tcnt_reg         <= '0;
               end else if (press && single_key && in_range) begin
                  digit_valid_reg <= 1'b1;
                  digit_reg       <= key_val;
                  digit_pos_reg   <= pos_reg;
                  tcnt_reg        <= '0;
                  if (pos_reg == POS_H_TEN) begin
                     h_ten_reg <= key_val;
                  end
                  if (pos_reg == POS_S_ONE) begin
                     entry_done_reg   <= 1'b1;
                     state_reg        <= IDLE;
                     entry_active_reg <= 1'b0;
                     pos_reg          <= POS_H_TEN;
                  end else begin
                     pos_reg <= pos_reg + 3'd1;
                  end
               end else begin
                  // Rejected presses do not refresh the inactivity timer.
                  key_reject_reg <= press;
                  tcnt_reg       <= tcnt_reg + TW'(1);
               end
            end

            default: begin
               state_reg        <= IDLE;
               entry_active_reg <= 1'b0;
               pos_reg          <= POS_H_TEN;
            end
         endcase
      end
   end

   assign digit        = digit_reg;
   assign digit_pos    = digit_pos_reg;
   assign digit_valid  = digit_valid_reg;
   assign entry_active = entry_active_reg;
   assign entry_done   = entry_done_reg;
   assign entry_abort  = entry_abort_reg;
   assign key_reject   = key_reject_reg;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry: expected digits are queued when a
// press is driven and checked by a monitor when digit_valid fires.
module tb_keypad_digit_entry;

   localparam int DEBOUNCE = 20;
   localparam int TIMEOUT  = 10000;

   typedef struct packed {
      logic [3:0] d;
      logic [2:0] p;
      logic       done;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [9:0] key_in;
   logic [3:0] digit;
   logic [2:0] digit_pos;
   logic       digit_valid;
   logic       entry_active;
   logic       entry_done;
   logic       entry_abort;
   logic       key_reject;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   n_valid = 0, n_done = 0, n_abort = 0, n_reject = 0;
   int   last_valid_cyc = 0, last_abort_cyc = 0;

   keypad_digit_entry #(
      .DEBOUNCE (DEBOUNCE),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .key_in       (key_in),
      .digit        (digit),
      .digit_pos    (digit_pos),
      .digit_valid  (digit_valid),
      .entry_active (entry_active),
      .entry_done   (entry_done),
      .entry_abort  (entry_abort),
      .key_reject   (key_reject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [9:0] keys, input int hold, input int gap);
      key_in = keys;
      step(hold);
      key_in = '0;
      step(gap);
   endtask

   task automatic do_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic push(input int d, input int p, input logic done);
      exp_t e;
      e.d    = 4'(d);
      e.p    = 3'(p);
      e.done = done;
      q.push_back(e);
   endtask

   function automatic int out_vec();
      return int'({digit, digit_pos, digit_valid, entry_active, entry_done, entry_abort, key_reject});
   endfunction

   // Monitor: one line per delivered digit, compared against the queue.
   always @(negedge clk) begin
      if (rst) begin
         if (digit_valid) begin
            exp_t e;
            n_valid++;
            last_valid_cyc = cyc;
            check("sb_nonempty", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               $display("[TB] cyc %0d digit=%0d pos=%0d done=%0b", cyc, digit, digit_pos, entry_done);
               check("digit", int'(digit), int'(e.d));
               check("digit_pos", int'(digit_pos), int'(e.p));
               check("entry_done", int'(entry_done), int'(e.done));
            end
         end else if (entry_done) begin
            check("done_without_valid", int'(entry_done), 0);
         end
         if (entry_done) n_done++;
         if (entry_abort) begin
            n_abort++;
            last_abort_cyc = cyc;
         end
         if (key_reject) n_reject++;
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, r0, d0, a0, c0;
      rst    = 1'b0;
      start  = 1'b0;
      key_in = '0;

      // Reset state
      step(3);
      check("reset_outputs", out_vec(), 0);
      rst = 1'b1;
      step(5);
      check("idle_after_reset", int'(entry_active), 0);

      // Full entry 1..6
      v0 = n_valid; d0 = n_done;
      do_start();
      check("active_after_start", int'(entry_active), 1);
      for (int k = 1; k <= 6; k++) begin
         push(k, k - 1, (k == 6));
         press(10'(1 << k), 30, 30);
      end
      check("full_valid_count", n_valid - v0, 6);
      check("full_done_count", n_done - d0, 1);
      check("inactive_after_done", int'(entry_active), 0);

      // Glitchy key 2 then a clean press with exact latency
      do_start();
      v0 = n_valid;
      for (int g = 0; g < 3; g++) begin
         key_in = 10'(1 << 2);
         step(3);
         key_in = '0;
         step(1);
      end
      step(30);
      check("glitch_no_valid", n_valid - v0, 0);
      push(2, 0, 1'b0);
      key_in = 10'(1 << 2);
      c0 = cyc;
      step(30);
      key_in = '0;
      step(30);
      check("clean_valid_count", n_valid - v0, 1);
      check("latency", last_valid_cyc - c0, DEBOUNCE + 3);

      // Range checks at pos0 and pos1
      do_start();
      v0 = n_valid; r0 = n_reject;
      press(10'(1 << 3), 30, 30);
      check("pos0_reject_3", n_reject - r0, 1);
      check("pos0_reject_no_valid", n_valid - v0, 0);
      push(2, 0, 1'b0);
      press(10'(1 << 2), 30, 30);
      press(10'(1 << 4), 30, 30);
      check("pos1_reject_4", n_reject - r0, 2);
      push(3, 1, 1'b0);
      press(10'(1 << 3), 30, 30);
      check("range_valid_count", n_valid - v0, 2);

      // Two-key chord then single key 7 with h_ten=1
      do_start();
      push(1, 0, 1'b0);
      press(10'(1 << 1), 30, 30);
      v0 = n_valid; r0 = n_reject;
      press(10'(1 << 1) | 10'(1 << 7), 30, 30);
      check("chord_reject", n_reject - r0, 1);
      check("chord_no_valid", n_valid - v0, 0);
      push(7, 1, 1'b0);
      press(10'(1 << 7), 30, 30);
      check("pos1_seven_valid", n_valid - v0, 1);

      // Timeout abort
      do_start();
      a0 = n_abort;
      push(1, 0, 1'b0);
      press(10'(1 << 1), 30, 0);
      for (int t = 0; t < TIMEOUT + 100 && n_abort == a0; t++) step(1);
      check("abort_seen", n_abort - a0, 1);
      check("abort_timing", last_abort_cyc - last_valid_cyc, TIMEOUT);
      check("inactive_after_abort", int'(entry_active), 0);
      v0 = n_valid; r0 = n_reject;
      press(10'(1 << 5), 30, 30);
      press(10'(1 << 1) | 10'(1 << 2), 30, 30);
      check("idle_press_no_valid", n_valid - v0, 0);
      check("idle_press_no_reject", n_reject - r0, 0);

      // Reset mid-entry at pos3
      do_start();
      push(1, 0, 1'b0);
      press(10'(1 << 1), 30, 30);
      push(2, 1, 1'b0);
      press(10'(1 << 2), 30, 30);
      push(3, 2, 1'b0);
      press(10'(1 << 3), 30, 30);
      key_in = 10'(1 << 4);
      step(5);
      check("active_before_reset", int'(entry_active), 1);
      rst = 1'b0;
      #1;
      check("async_reset_outputs", out_vec(), 0);
      key_in = '0;
      step(3);
      rst = 1'b1;
      v0 = n_valid; r0 = n_reject; d0 = n_done; a0 = n_abort;
      step(30);
      press(10'(1 << 4), 30, 30);
      check("post_reset_no_valid", n_valid - v0, 0);
      check("post_reset_no_reject", n_reject - r0, 0);
      check("post_reset_no_done_abort", (n_done - d0) + (n_abort - a0), 0);
      check("scoreboard_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
